// File: rtl/cpu_ser_src_if.sv
// rtl/cpu_ser_src_if.sv - producer and CPU strobe/status bundle for cpu_ser_src
interface cpu_ser_src_if #(
  parameter int W = 32
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         load;
  logic         rd_bit;
  logic         clr;
  logic         ser;
  logic [15:0]  status;

  modport master (
    output in_data, in_valid, load, rd_bit, clr,
    input  in_ready, ser, status
  );

  modport slave (
    input  in_data, in_valid, load, rd_bit, clr,
    output in_ready, ser, status
  );
endinterface

// File: rtl/cpu_ser_src.sv
// rtl/cpu_ser_src.sv - FIFO-buffered MSB-first serial source for the CPU rdBit path
// Optional macro SER_SRC_OVF_DROP_EN: never stall the producer, drop pushes while full and flag ovf.
module cpu_ser_src #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_ser_src_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sr_state_t;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [3:0]    r_count;
  logic [W-1:0]  r_sr;
  logic [5:0]    r_bits_left;
  logic          r_unf;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf;
  sr_state_t     w_state;
  logic [W-1:0]  w_sr_nxt;
  logic [5:0]    w_bits_nxt;
  logic [3:0]    w_count_nxt;

  assign w_full  = (r_count == 4'(DEPTH));
  assign w_empty = (r_count == 4'd0);
  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign w_push  = bus.in_valid && !w_full;
  assign w_pop   = bus.load && !w_empty;
  assign w_state = (r_bits_left == 6'd0) ? ST_IDLE : ST_SHIFT;

`ifdef SER_SRC_OVF_DROP_EN
  logic r_ovf;

  assign bus.in_ready = 1'b1;
  assign w_ovf        = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (bus.in_valid && w_full) begin
      r_ovf <= 1'b1;
    end else if (bus.clr) begin
      r_ovf <= 1'b0;
    end
  end
`else
  assign bus.in_ready = !w_full;
  assign w_ovf        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 4'd1;
      2'b01:   w_count_nxt = r_count - 4'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Load takes priority over rd_bit; an unfinished word is simply overwritten.
  always_comb begin
    w_sr_nxt   = r_sr;
    w_bits_nxt = r_bits_left;
    if (bus.load) begin
      if (!w_empty) begin
        w_sr_nxt   = r_mem[r_rd_ptr];
        w_bits_nxt = 6'(W);
      end else begin
        w_sr_nxt   = '0;
        w_bits_nxt = 6'd0;
      end
    end else if (bus.rd_bit) begin
      w_sr_nxt = {r_sr[W-2:0], 1'b0};
      if (w_state == ST_SHIFT) begin
        w_bits_nxt = r_bits_left - 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= 4'd0;
      r_sr        <= '0;
      r_bits_left <= 6'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count     <= w_count_nxt;
      r_sr        <= w_sr_nxt;
      r_bits_left <= w_bits_nxt;
    end
  end

  // A set in the same cycle as clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_unf <= 1'b0;
    end else if (bus.load && w_empty) begin
      r_unf <= 1'b1;
    end else if (bus.clr) begin
      r_unf <= 1'b0;
    end
  end

  assign bus.ser    = r_sr[W-1];
  assign bus.status = {r_unf, w_ovf, r_bits_left, 4'b0000, r_count};
endmodule

// File: tb/tb_cpu_ser_src.sv
// tb/tb_cpu_ser_src.sv - scoreboard bench for cpu_ser_src
module tb_cpu_ser_src;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [31:0] word_q[$];
  logic        bit_q[$];

  cpu_ser_src_if #(.W(32)) bus();

  cpu_ser_src #(.W(32), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic read_word(input bit do_load, output logic [31:0] w);
    w = '0;
    if (do_load) begin
      bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
    end
    for (int k = 0; k < 32; k++) begin
      w = {w[30:0], bus.ser};
      bus.rd_bit = 1'b1;
      tick();
    end
    bus.rd_bit = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    n_vec++;
    if (bus.status !== 16'h0000 || bus.ser !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: status=%h ser=%b in_ready=%b expected 0000/0/1", bus.status, bus.ser, bus.in_ready);
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_async_reset;
    push_one(32'h8000_0001);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    n_vec++;
    if (bus.ser !== 1'b1) begin
      n_err++;
      $display("FAIL async_pre_ser: ser=%b expected 1", bus.ser);
    end
    bus.rd_bit = 1'b1;
    repeat (3) tick();
    bus.rd_bit = 1'b0;
    n_vec++;
    if (bus.status !== 16'h1D00) begin
      n_err++;
      $display("FAIL async_pre_status: status=%h expected 1d00", bus.status);
    end
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.status !== 16'h0000 || bus.ser !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: status=%h ser=%b in_ready=%b expected 0000/0/1", bus.status, bus.ser, bus.in_ready);
    end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_shift;
    logic [31:0] w;
    logic        e;
    w = 32'hA5A5_0003;
    for (int k = 31; k >= 0; k--) bit_q.push_back(w[k]);
    push_one(w);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 32; i++) begin
      e = bit_q.pop_front();
      n_vec++;
      if (bus.ser !== e || bus.status[13:8] !== 6'(32 - i)) begin
        n_err++;
        $display("FAIL shift_bit%0d: ser=%b bits_left=%0d expected %b/%0d", i, bus.ser, bus.status[13:8], e, 32 - i);
      end
      bus.rd_bit = 1'b1;
      tick();
    end
    n_vec++;
    if (bus.ser !== 1'b0 || bus.status !== 16'h0000) begin
      n_err++;
      $display("FAIL shift_done: ser=%b status=%h expected 0/0000", bus.ser, bus.status);
    end
    tick();
    bus.rd_bit = 1'b0;
    n_vec++;
    if (bus.ser !== 1'b0 || bus.status !== 16'h0000) begin
      n_err++;
      $display("FAIL shift_extra: ser=%b status=%h expected 0/0000", bus.ser, bus.status);
    end
  endtask

  task automatic test_fifo_full;
    logic [31:0] got;
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      bus.in_data  = 32'hC0DE_0000 + 32'(i);
      bus.in_valid = 1'b1;
      n_vec++;
      if (bus.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL fill_ready%0d: in_ready=%b expected 1", i, bus.in_ready);
      end
      word_q.push_back(bus.in_data);
      tick();
    end
    bus.in_data = 32'hC0DE_0004;
    n_vec++;
    if (bus.in_ready !== 1'b0 || bus.status[3:0] !== 4'd4) begin
      n_err++;
      $display("FAIL full: in_ready=%b count=%0d expected 0/4", bus.in_ready, bus.status[3:0]);
    end
    tick();
    n_vec++;
    if (bus.status[3:0] !== 4'd4) begin
      n_err++;
      $display("FAIL full_hold: count=%0d expected 4", bus.status[3:0]);
    end
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.status[3:0] !== 4'd3) begin
      n_err++;
      $display("FAIL after_pop: in_ready=%b count=%0d expected 1/3", bus.in_ready, bus.status[3:0]);
    end
    word_q.push_back(bus.in_data);
    tick();
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.status[3:0] !== 4'd4) begin
      n_err++;
      $display("FAIL fifth_in: count=%0d expected 4", bus.status[3:0]);
    end
    read_word(1'b0, got);
    exp = word_q.pop_front();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL order0: got=%h expected %h", got, exp);
    end
    for (int i = 1; i < 5; i++) begin
      read_word(1'b1, got);
      exp = word_q.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL order%0d: got=%h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got;
    logic [31:0] exp;
    push_one(32'h1234_5678);
    word_q.push_back(32'h1234_5678);
    bus.in_data  = 32'h9ABC_DEF0;
    bus.in_valid = 1'b1;
    bus.load     = 1'b1;
    word_q.push_back(32'h9ABC_DEF0);
    tick();
    bus.in_valid = 1'b0;
    bus.load     = 1'b0;
    n_vec++;
    if (bus.status[3:0] !== 4'd1 || bus.status[13:8] !== 6'd32) begin
      n_err++;
      $display("FAIL push_pop: count=%0d bits_left=%0d expected 1/32", bus.status[3:0], bus.status[13:8]);
    end
    read_word(1'b0, got);
    exp = word_q.pop_front();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL b2b_w0: got=%h expected %h", got, exp);
    end
    read_word(1'b1, got);
    exp = word_q.pop_front();
    n_vec++;
    if (got !== exp || bus.status[3:0] !== 4'd0) begin
      n_err++;
      $display("FAIL b2b_w1: got=%h count=%0d expected %h/0", got, bus.status[3:0], exp);
    end
  endtask

  task automatic test_underflow;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    n_vec++;
    if (bus.status[15] !== 1'b1 || bus.ser !== 1'b0 || bus.status[13:8] !== 6'd0) begin
      n_err++;
      $display("FAIL unf_set: unf=%b ser=%b bits_left=%0d expected 1/0/0", bus.status[15], bus.ser, bus.status[13:8]);
    end
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    n_vec++;
    if (bus.status[15] !== 1'b0) begin
      n_err++;
      $display("FAIL unf_clr: unf=%b expected 0", bus.status[15]);
    end
    bus.load = 1'b1;
    bus.clr  = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.clr  = 1'b0;
    n_vec++;
    if (bus.status[15] !== 1'b1) begin
      n_err++;
      $display("FAIL unf_set_wins: unf=%b expected 1", bus.status[15]);
    end
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  task automatic test_load_rdbit;
    logic [31:0] got;
    push_one(32'h4000_0000);
    push_one(32'hFFFF_FFFF);
    bus.load = 1'b1;
    tick();
    n_vec++;
    if (bus.ser !== 1'b0 || bus.status[3:0] !== 4'd1) begin
      n_err++;
      $display("FAIL lr_first: ser=%b count=%0d expected 0/1", bus.ser, bus.status[3:0]);
    end
    bus.rd_bit = 1'b1;
    tick();
    bus.load   = 1'b0;
    bus.rd_bit = 1'b0;
    n_vec++;
    if (bus.ser !== 1'b1 || bus.status[13:8] !== 6'd32 || bus.status[3:0] !== 4'd0) begin
      n_err++;
      $display("FAIL lr_load_wins: ser=%b bits_left=%0d count=%0d expected 1/32/0", bus.ser, bus.status[13:8], bus.status[3:0]);
    end
    read_word(1'b0, got);
    n_vec++;
    if (got !== 32'hFFFF_FFFF || bus.status[13:8] !== 6'd0) begin
      n_err++;
      $display("FAIL lr_word: got=%h bits_left=%0d expected ffffffff/0", got, bus.status[13:8]);
    end
  endtask

  task automatic test_ovf;
    logic [31:0] got;
    logic [31:0] exp;
`ifdef SER_SRC_OVF_DROP_EN
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (bus.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL ovf_ready%0d: in_ready=%b expected 1", i, bus.in_ready);
      end
      if (i < 4) word_q.push_back(32'h0BAD_0000 + 32'(i));
      push_one(32'h0BAD_0000 + 32'(i));
    end
    n_vec++;
    if (bus.status[3:0] !== 4'd4 || bus.status[14] !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set: count=%0d ovf=%b expected 4/1", bus.status[3:0], bus.status[14]);
    end
`else
    for (int i = 0; i < 4; i++) begin
      word_q.push_back(32'h0BAD_0000 + 32'(i));
      push_one(32'h0BAD_0000 + 32'(i));
    end
    bus.in_data  = 32'h0BAD_0004;
    bus.in_valid = 1'b1;
    repeat (2) tick();
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.status[3:0] !== 4'd4 || bus.status[14] !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL no_ovf: count=%0d ovf=%b in_ready=%b expected 4/0/0", bus.status[3:0], bus.status[14], bus.in_ready);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      read_word(1'b1, got);
      exp = word_q.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL ovf_pop%0d: got=%h expected %h", i, got, exp);
      end
    end
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    n_vec++;
    if (bus.status !== 16'h0000) begin
      n_err++;
      $display("FAIL ovf_end: status=%h expected 0000", bus.status);
    end
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.load     = 1'b0;
    bus.rd_bit   = 1'b0;
    bus.clr      = 1'b0;
    test_reset();
    test_async_reset();
    test_shift();
    test_fifo_full();
    test_back_to_back();
    test_underflow();
    test_load_rdbit();
    test_ovf();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
